// File: rtl/ddr_cke_lpbk_checker_if.sv
`timescale 1ns/1ps
// Control, status and pad-side signals of the CKE loopback checker.
//
// Handshake: i_start is a one-cycle request accepted only while the checker
// is idle (o_state == 0); acceptance is visible one cycle later as o_busy.
// Completion is the single-cycle o_done pulse; o_pass, o_err_cnt and
// o_first_err_idx are valid from that cycle and hold until the next accepted
// i_start. i_abort cancels any run in progress and never produces o_done.
interface ddr_cke_lpbk_checker_if #(
    parameter int CNT_WIDTH = 16,
    parameter int LAT_WIDTH = 4
);
    logic                 i_start;
    logic                 i_abort;
    logic                 i_mode;
    logic [6:0]           i_seed;
    logic [LAT_WIDTH-1:0] i_lat;
    logic [CNT_WIDTH-1:0] i_num_bits;
    logic                 i_d_lpbk;
    logic                 o_d_n;
    logic                 o_oe;
    logic                 o_lpbk_en;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_pass;
    logic [CNT_WIDTH-1:0] o_err_cnt;
    logic [CNT_WIDTH-1:0] o_first_err_idx;
    logic [1:0]           o_state;

    modport master (
        output i_start, i_abort, i_mode, i_seed, i_lat, i_num_bits, i_d_lpbk,
        input  o_d_n, o_oe, o_lpbk_en, o_busy, o_done, o_pass, o_err_cnt,
               o_first_err_idx, o_state
    );

    modport slave (
        input  i_start, i_abort, i_mode, i_seed, i_lat, i_num_bits, i_d_lpbk,
        output o_d_n, o_oe, o_lpbk_en, o_busy, o_done, o_pass, o_err_cnt,
               o_first_err_idx, o_state
    );
endinterface

// File: rtl/ddr_cke_lpbk_checker.sv
`timescale 1ns/1ps
// CKE pad loopback pattern generator and checker. Drives PRBS7 or a toggle
// pattern (inverted) into the driver, resynchronises the loopback return and
// compares it against the transmitted history tapped at the programmed
// round-trip latency.
module ddr_cke_lpbk_checker #(
    parameter int CNT_WIDTH = 16,
    parameter int LAT_WIDTH = 4
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    ddr_cke_lpbk_checker_if.slave   bus
);
    localparam int HIST_DEPTH = 2**LAT_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [6:0]           lfsr, lfsr_nxt;
    logic                 tog, tog_nxt;
    logic                 mode_q, mode_nxt;
    logic [LAT_WIDTH-1:0] lat_q, lat_nxt;
    logic [CNT_WIDTH-1:0] num_q, num_nxt;
    logic [CNT_WIDTH-1:0] cmp_cnt, cmp_cnt_nxt;
    logic [CNT_WIDTH-1:0] err_cnt, err_cnt_nxt;
    logic [CNT_WIDTH-1:0] first_idx, first_idx_nxt;
    logic [LAT_WIDTH:0]   fill_cnt, fill_cnt_nxt;
    logic [HIST_DEPTH-1:0] hist, hist_nxt;
    logic                 s1, s2;
    logic                 d_n, d_n_nxt;
    logic                 oe, oe_nxt;
    logic                 lpbk_en, lpbk_en_nxt;
    logic                 busy, busy_nxt;
    logic                 done, done_nxt;
    logic                 pass, pass_nxt;
    logic                 finish;

    logic [6:0]           seed_eff;
    logic                 start_bit;
    logic                 tx_bit;
    logic [LAT_WIDTH:0]   tap_idx;
    logic                 mismatch;

    // A zero seed would lock the LFSR, so it is replaced by all-ones.
    assign seed_eff  = (bus.i_seed == 7'h00) ? 7'h7F : bus.i_seed;
    assign start_bit = bus.i_mode ? 1'b1 : seed_eff[6];
    assign tx_bit    = mode_q ? tog : lfsr[6];
    // hist[0] is the bit on the pad now; the two synchronizer flops add 2.
    assign tap_idx   = {1'b0, lat_q} + (LAT_WIDTH+1)'(2);
    assign mismatch  = s2 ^ hist[tap_idx];

    // Next-state and next-output decode for the run sequencer.
    always_comb begin
        state_nxt     = state;
        lfsr_nxt      = lfsr;
        tog_nxt       = tog;
        mode_nxt      = mode_q;
        lat_nxt       = lat_q;
        num_nxt       = num_q;
        cmp_cnt_nxt   = cmp_cnt;
        err_cnt_nxt   = err_cnt;
        first_idx_nxt = first_idx;
        fill_cnt_nxt  = fill_cnt;
        hist_nxt      = hist;
        d_n_nxt       = d_n;
        oe_nxt        = oe;
        lpbk_en_nxt   = lpbk_en;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        pass_nxt      = pass;
        finish        = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_nxt     = S_FILL;
                    mode_nxt      = bus.i_mode;
                    lat_nxt       = bus.i_lat;
                    num_nxt       = bus.i_num_bits;
                    lfsr_nxt      = {seed_eff[5:0], seed_eff[6] ^ seed_eff[5]};
                    tog_nxt       = 1'b0;
                    hist_nxt      = {hist[HIST_DEPTH-2:0], start_bit};
                    d_n_nxt       = ~start_bit;
                    cmp_cnt_nxt   = '0;
                    err_cnt_nxt   = '0;
                    first_idx_nxt = '1;
                    fill_cnt_nxt  = '0;
                    oe_nxt        = 1'b1;
                    lpbk_en_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    pass_nxt      = 1'b0;
                end
            end
            S_FILL, S_CHECK: begin
                if (bus.i_abort) begin
                    state_nxt   = S_IDLE;
                    d_n_nxt     = 1'b1;
                    oe_nxt      = 1'b0;
                    lpbk_en_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
                end else begin
                    lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                    tog_nxt  = ~tog;
                    hist_nxt = {hist[HIST_DEPTH-2:0], tx_bit};
                    d_n_nxt  = ~tx_bit;
                    if (state == S_FILL) begin
                        if (fill_cnt == {1'b0, lat_q} + (LAT_WIDTH+1)'(1)) begin
                            if (num_q == '0) begin
                                finish = 1'b1;
                            end else begin
                                state_nxt = S_CHECK;
                            end
                        end else begin
                            fill_cnt_nxt = fill_cnt + 1'b1;
                        end
                    end else begin
                        if (mismatch) begin
                            if (err_cnt != '1) begin
                                err_cnt_nxt = err_cnt + 1'b1;
                            end
                            if (err_cnt == '0) begin
                                first_idx_nxt = cmp_cnt;
                            end
                        end
                        cmp_cnt_nxt = cmp_cnt + 1'b1;
                        if (cmp_cnt == num_q - 1'b1) begin
                            finish = 1'b1;
                        end
                    end
                    if (finish) begin
                        state_nxt   = S_DONE;
                        done_nxt    = 1'b1;
                        pass_nxt    = (err_cnt_nxt == '0);
                        d_n_nxt     = 1'b1;
                        oe_nxt      = 1'b0;
                        lpbk_en_nxt = 1'b0;
                        busy_nxt    = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                if (bus.i_abort) begin
                    pass_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            lfsr      <= 7'h7F;
            tog       <= 1'b0;
            mode_q    <= 1'b0;
            lat_q     <= '0;
            num_q     <= '0;
            cmp_cnt   <= '0;
            err_cnt   <= '0;
            first_idx <= '1;
            fill_cnt  <= '0;
            hist      <= '0;
            d_n       <= 1'b1;
            oe        <= 1'b0;
            lpbk_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            tog       <= tog_nxt;
            mode_q    <= mode_nxt;
            lat_q     <= lat_nxt;
            num_q     <= num_nxt;
            cmp_cnt   <= cmp_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            first_idx <= first_idx_nxt;
            fill_cnt  <= fill_cnt_nxt;
            hist      <= hist_nxt;
            d_n       <= d_n_nxt;
            oe        <= oe_nxt;
            lpbk_en   <= lpbk_en_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
        end
    end

    // Two-flop synchronizer for the asynchronous loopback return.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.i_d_lpbk;
            s2 <= s1;
        end
    end

    assign bus.o_d_n           = d_n;
    assign bus.o_oe            = oe;
    assign bus.o_lpbk_en       = lpbk_en;
    assign bus.o_busy          = busy;
    assign bus.o_done          = done;
    assign bus.o_pass          = pass;
    assign bus.o_err_cnt       = err_cnt;
    assign bus.o_first_err_idx = first_idx;
    assign bus.o_state         = state;
endmodule

// File: tb/tb_ddr_cke_lpbk_checker.sv
`timescale 1ns/1ps
// Directed bench for the CKE loopback checker: zero-delay and delayed
// loopback, stuck and single-flip faults, abort, zero-length and reset.
module tb_ddr_cke_lpbk_checker;
    localparam int CW = 16;
    localparam int LW = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr_cke_lpbk_checker_if #(.CNT_WIDTH(CW), .LAT_WIDTH(LW)) bus();

    ddr_cke_lpbk_checker #(.CNT_WIDTH(CW), .LAT_WIDTH(LW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc_cnt = 0;

    // loopback model: 0 = wire, 1 = 3-cycle delay, 2 = stuck
    logic [1:0] lp_sel    = 2'd0;
    logic       stuck_val = 1'b0;
    logic       flip      = 1'b0;
    logic [7:0] dly_line;
    logic       lp_val;

    always @(posedge clk) dly_line <= {dly_line[6:0], ~bus.o_d_n};

    always_comb begin
        lp_val = ~bus.o_d_n;
        case (lp_sel)
            2'd1:    lp_val = dly_line[2];
            2'd2:    lp_val = stuck_val;
            default: lp_val = ~bus.o_d_n;
        endcase
    end

    assign bus.i_d_lpbk = lp_val ^ flip;

    // driver tasks
    task automatic tick();
        @(negedge clk);
        cyc_cnt++;
    endtask

    task automatic start_run(input logic mode, input logic [6:0] seed,
                             input logic [LW-1:0] lat, input logic [CW-1:0] num,
                             input logic with_abort);
        repeat (5) @(negedge clk);
        bus.i_mode     = mode;
        bus.i_seed     = seed;
        bus.i_lat      = lat;
        bus.i_num_bits = num;
        bus.i_start    = 1'b1;
        bus.i_abort    = with_abort;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_abort    = 1'b0;
        cyc_cnt        = 1;
    endtask

    task automatic wait_done(input int budget);
        while (bus.o_done !== 1'b1 && cyc_cnt < budget) tick();
    endtask

    // PRBS7 x^7+x^6+1 reference: count bits differing from the previous one
    function automatic int prbs_transitions(input int n);
        logic [6:0] r;
        logic       prev;
        int         e;
        r    = 7'h7F;
        prev = 1'b0;
        e    = 0;
        for (int i = 0; i < n; i++) begin
            if (r[6] != prev) e++;
            prev = r[6];
            r    = {r[5:0], r[6] ^ r[5]};
        end
        return e;
    endfunction

    task automatic test_reset();
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_mode = 1'b0;
        bus.i_seed = 7'h00; bus.i_lat = '0; bus.i_num_bits = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_d_n, bus.o_oe, bus.o_lpbk_en, bus.o_busy, bus.o_done, bus.o_pass} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 100000",
                     {bus.o_d_n, bus.o_oe, bus.o_lpbk_en, bus.o_busy, bus.o_done, bus.o_pass});
        end
        checks++;
        if (bus.o_err_cnt !== 16'h0000 || bus.o_first_err_idx !== 16'hFFFF || bus.o_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_counts got err=%h idx=%h st=%0d exp 0000 ffff 0",
                     bus.o_err_cnt, bus.o_first_err_idx, bus.o_state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_prbs_wire();
        logic [6:0] bits;
        lp_sel = 2'd0;
        start_run(1'b0, 7'h00, 4'd0, 16'd200, 1'b0);
        checks++;
        if ({bus.o_oe, bus.o_busy, bus.o_lpbk_en} !== 3'b111) begin
            errors++;
            $display("FAIL start_enables got %b exp 111", {bus.o_oe, bus.o_busy, bus.o_lpbk_en});
        end
        bits = '0;
        for (int i = 0; i < 7; i++) begin
            bits = {bits[5:0], ~bus.o_d_n};
            tick();
        end
        checks++;
        if (bits !== 7'h7F) begin
            errors++;
            $display("FAIL prbs_first_bits got %h exp 7f", bits);
        end
        wait_done(400);
        checks++;
        if (bus.o_done !== 1'b1 || cyc_cnt != 203) begin
            errors++;
            $display("FAIL prbs_done_cycles got %0d done=%b exp 203", cyc_cnt, bus.o_done);
        end
        checks++;
        if (bus.o_pass !== 1'b1 || bus.o_err_cnt !== 16'd0 || bus.o_first_err_idx !== 16'hFFFF) begin
            errors++;
            $display("FAIL prbs_result got pass=%b err=%0d idx=%h exp 1 0 ffff",
                     bus.o_pass, bus.o_err_cnt, bus.o_first_err_idx);
        end
        checks++;
        if (bus.o_oe !== 1'b0 || bus.o_d_n !== 1'b1 || bus.o_lpbk_en !== 1'b0) begin
            errors++;
            $display("FAIL done_pad got oe=%b d_n=%b lpbk=%b exp 0 1 0", bus.o_oe, bus.o_d_n, bus.o_lpbk_en);
        end
        tick();
        checks++;
        if (bus.o_done !== 1'b0 || bus.o_pass !== 1'b1 || bus.o_state !== 2'd0) begin
            errors++;
            $display("FAIL done_pulse_hold got done=%b pass=%b st=%0d exp 0 1 0",
                     bus.o_done, bus.o_pass, bus.o_state);
        end
    endtask

    task automatic test_latency();
        int exp_err;
        lp_sel = 2'd1;
        start_run(1'b0, 7'h00, 4'd3, 16'd200, 1'b0);
        wait_done(400);
        checks++;
        if (bus.o_done !== 1'b1 || cyc_cnt != 206 || bus.o_pass !== 1'b1 || bus.o_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL lat3_pass got cyc=%0d pass=%b err=%0d exp 206 1 0", cyc_cnt, bus.o_pass, bus.o_err_cnt);
        end
        exp_err = prbs_transitions(200);
        start_run(1'b0, 7'h00, 4'd2, 16'd200, 1'b0);
        wait_done(400);
        checks++;
        if (bus.o_done !== 1'b1 || cyc_cnt != 205 || bus.o_pass !== 1'b0 ||
            int'(bus.o_err_cnt) != exp_err || bus.o_first_err_idx !== 16'd0) begin
            errors++;
            $display("FAIL lat2_fail got cyc=%0d pass=%b err=%0d idx=%0d exp 205 0 %0d 0",
                     cyc_cnt, bus.o_pass, bus.o_err_cnt, bus.o_first_err_idx, exp_err);
        end
        lp_sel = 2'd0;
    endtask

    task automatic test_toggle_stuck();
        lp_sel = 2'd2;
        stuck_val = 1'b0;
        start_run(1'b1, 7'h11, 4'd0, 16'd10, 1'b0);
        wait_done(100);
        checks++;
        if (bus.o_done !== 1'b1 || cyc_cnt != 13 || bus.o_err_cnt !== 16'd5 ||
            bus.o_first_err_idx !== 16'd0 || bus.o_pass !== 1'b0) begin
            errors++;
            $display("FAIL toggle_stuck got cyc=%0d err=%0d idx=%0d pass=%b exp 13 5 0 0",
                     cyc_cnt, bus.o_err_cnt, bus.o_first_err_idx, bus.o_pass);
        end
        lp_sel = 2'd0;
    endtask

    task automatic test_single_flip();
        lp_sel = 2'd0;
        start_run(1'b0, 7'h25, 4'd0, 16'd64, 1'b0);
        repeat (37) tick();
        flip = 1'b1;
        tick();
        flip = 1'b0;
        wait_done(200);
        checks++;
        if (bus.o_done !== 1'b1 || cyc_cnt != 67 || bus.o_err_cnt !== 16'd1 ||
            bus.o_first_err_idx !== 16'd37 || bus.o_pass !== 1'b0) begin
            errors++;
            $display("FAIL single_flip got cyc=%0d err=%0d idx=%0d pass=%b exp 67 1 37 0",
                     cyc_cnt, bus.o_err_cnt, bus.o_first_err_idx, bus.o_pass);
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        lp_sel = 2'd0;
        start_run(1'b0, 7'h3C, 4'd0, 16'd100, 1'b0);
        repeat (22) tick();
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        checks++;
        if ({bus.o_oe, bus.o_lpbk_en, bus.o_busy, bus.o_done, bus.o_pass} !== 5'b00000 || bus.o_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_outputs got %b st=%0d exp 00000 0",
                     {bus.o_oe, bus.o_lpbk_en, bus.o_busy, bus.o_done, bus.o_pass}, bus.o_state);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (bus.o_done === 1'b1) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_done !== 1'b0 || bus.o_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL abort_no_done got done_seen=%b err=%0d exp 0 0", seen_done, bus.o_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        // start and abort together in IDLE must start; a mid-run start and
        // latency change are ignored
        lp_sel = 2'd0;
        start_run(1'b0, 7'h5A, 4'd0, 16'd30, 1'b1);
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_oe !== 1'b1) begin
            errors++;
            $display("FAIL start_with_abort got busy=%b oe=%b exp 1 1", bus.o_busy, bus.o_oe);
        end
        repeat (8) tick();
        bus.i_start = 1'b1;
        bus.i_lat   = 4'd7;
        tick();
        bus.i_start = 1'b0;
        wait_done(100);
        checks++;
        if (bus.o_done !== 1'b1 || cyc_cnt != 33 || bus.o_pass !== 1'b1 || bus.o_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL back_to_back got cyc=%0d pass=%b err=%0d exp 33 1 0", cyc_cnt, bus.o_pass, bus.o_err_cnt);
        end
    endtask

    task automatic test_zero_bits();
        lp_sel = 2'd2;
        stuck_val = 1'b1;
        start_run(1'b1, 7'h00, 4'd0, 16'd0, 1'b0);
        wait_done(50);
        checks++;
        if (bus.o_done !== 1'b1 || cyc_cnt != 3 || bus.o_pass !== 1'b1 ||
            bus.o_err_cnt !== 16'd0 || bus.o_first_err_idx !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_bits got cyc=%0d pass=%b err=%0d idx=%h exp 3 1 0 ffff",
                     cyc_cnt, bus.o_pass, bus.o_err_cnt, bus.o_first_err_idx);
        end
        lp_sel = 2'd0;
    endtask

    task automatic test_reset_mid_run();
        logic seen_done;
        lp_sel = 2'd2;
        stuck_val = 1'b0;
        start_run(1'b1, 7'h00, 4'd0, 16'd50, 1'b0);
        repeat (20) tick();
        checks++;
        if (bus.o_err_cnt === 16'd0) begin
            errors++;
            $display("FAIL pre_reset_errors got %0d exp nonzero", bus.o_err_cnt);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.o_d_n, bus.o_oe, bus.o_lpbk_en, bus.o_busy, bus.o_done, bus.o_pass} !== 6'b100000 ||
            bus.o_err_cnt !== 16'd0 || bus.o_first_err_idx !== 16'hFFFF || bus.o_state !== 2'd0) begin
            errors++;
            $display("FAIL mid_run_reset got flags=%b err=%0d idx=%h st=%0d exp 100000 0 ffff 0",
                     {bus.o_d_n, bus.o_oe, bus.o_lpbk_en, bus.o_busy, bus.o_done, bus.o_pass},
                     bus.o_err_cnt, bus.o_first_err_idx, bus.o_state);
        end
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.o_done === 1'b1) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got done_seen=%b exp 0", seen_done);
        end
        lp_sel = 2'd0;
    endtask

    initial begin
        test_reset();
        test_prbs_wire();
        test_latency();
        test_toggle_stuck();
        test_single_flip();
        test_abort();
        test_back_to_back();
        test_zero_bits();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
